// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core load/store port (0) and a debug/loader
// port (1). Port 1 may lock the memory, but only for a bounded number of cycles.
module dmem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_LOCK = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_valid,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ready,
   output logic              m0_resp_valid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_valid,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ready,
   output logic              m1_resp_valid,
   output logic [DATA_W-1:0] m1_rdata,
   input  logic              m1_lock,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd,
   output logic              core_stall,
   output logic              lock_active
);

   typedef enum logic [1:0] {
      ST_RR,
      ST_LOCKED,
      ST_FORCE
   } state_t;

   localparam logic [7:0] LOCK_LIMIT = 8'(MAX_LOCK);

   state_t            r_state;
   state_t            w_nextState;
   logic              r_lastGrant;
   logic [7:0]        r_lockCnt;
   logic [7:0]        w_nextLockCnt;
   logic [7:0]        w_lockInc;
   logic              w_grant0;
   logic              w_grant1;
   logic              r_m0RespValid;
   logic              r_m1RespValid;
   logic [DATA_W-1:0] r_m0Rdata;
   logic [DATA_W-1:0] r_m1Rdata;

   assign w_lockInc = r_lockCnt + 8'd1;

   // Grant selection and next state; a forced cycle hands the memory back to the core.
   always_comb begin
      w_grant0      = 1'b0;
      w_grant1      = 1'b0;
      w_nextState   = r_state;
      w_nextLockCnt = r_lockCnt;
      case (r_state)
         ST_RR: begin
            if (m0_valid && m1_valid) begin
               w_grant0 = r_lastGrant;
               w_grant1 = ~r_lastGrant;
            end else begin
               w_grant0 = m0_valid;
               w_grant1 = m1_valid;
            end
            if (w_grant1 && m1_lock) begin
               w_nextLockCnt = 8'd1;
               w_nextState   = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (m1_lock) begin
               w_grant1      = m1_valid;
               w_nextLockCnt = w_lockInc;
               if (w_lockInc == LOCK_LIMIT) begin
                  w_nextState = ST_FORCE;
               end
            end else begin
               w_grant0      = m0_valid;
               w_grant1      = ~m0_valid & m1_valid;
               w_nextLockCnt = 8'd0;
               w_nextState   = ST_RR;
            end
         end
         ST_FORCE: begin
            w_grant0      = m0_valid;
            w_grant1      = ~m0_valid & m1_valid;
            w_nextLockCnt = 8'd0;
            w_nextState   = ST_RR;
         end
         default: begin
            w_nextLockCnt = 8'd0;
            w_nextState   = ST_RR;
         end
      endcase
      if (rst) begin
         w_grant0 = 1'b0;
         w_grant1 = 1'b0;
      end
   end

   // The granted port drives the memory; an idle cycle presents all zeros.
   always_comb begin
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_wd   = '0;
      if (w_grant0) begin
         mem_we   = m0_we;
         mem_addr = m0_addr;
         mem_wd   = m0_wdata;
      end else if (w_grant1) begin
         mem_we   = m1_we;
         mem_addr = m1_addr;
         mem_wd   = m1_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_RR;
         r_lastGrant   <= 1'b1;
         r_lockCnt     <= 8'd0;
         r_m0RespValid <= 1'b0;
         r_m1RespValid <= 1'b0;
         r_m0Rdata     <= '0;
         r_m1Rdata     <= '0;
      end else begin
         r_state       <= w_nextState;
         r_lockCnt     <= w_nextLockCnt;
         r_m0RespValid <= w_grant0;
         r_m1RespValid <= w_grant1;
         if (w_grant0) begin
            r_lastGrant <= 1'b0;
            r_m0Rdata   <= m0_we ? '0 : mem_rd;
         end
         if (w_grant1) begin
            r_lastGrant <= 1'b1;
            r_m1Rdata   <= m1_we ? '0 : mem_rd;
         end
      end
   end

   assign m0_ready      = w_grant0;
   assign m1_ready      = w_grant1;
   assign m0_resp_valid = r_m0RespValid;
   assign m1_resp_valid = r_m1RespValid;
   assign m0_rdata      = r_m0Rdata;
   assign m1_rdata      = r_m1Rdata;
   assign core_stall    = m0_valid & ~w_grant0;
   assign lock_active   = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: scenario tasks check grants and memory drive,
// while a negedge monitor compares responses against a scoreboard of expected reads.
module tb_dmem_arbiter;

   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int MAX_LOCK = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              m0_valid, m0_we, m0_ready, m0_resp_valid;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata, m0_rdata;
   logic              m1_valid, m1_we, m1_ready, m1_resp_valid, m1_lock;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata, m1_rdata;
   logic              mem_we, core_stall, lock_active;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wd, mem_rd;

   typedef struct {
      int          port;
      logic [31:0] rdata;
      int          due;
   } resp_t;

   resp_t       sb[$];
   int          checks  = 0;
   int          errors  = 0;
   int          cycleNo = 0;
   bit          monitorOn = 1'b0;
   bit          rstSeen   = 1'b0;
   logic [31:0] expRd0 = '0;
   logic [31:0] expRd1 = '0;

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
      .clk(clk), .rst(rst),
      .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ready(m0_ready), .m0_resp_valid(m0_resp_valid), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ready(m1_ready), .m1_resp_valid(m1_resp_valid), .m1_rdata(m1_rdata),
      .m1_lock(m1_lock), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
      .mem_rd(mem_rd), .core_stall(core_stall), .lock_active(lock_active)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cycleNo <= cycleNo + 1;
      rstSeen <= rst;
   end

   // Response monitor: pops the entry due this cycle and checks both ports' outputs.
   always @(negedge clk) begin : monitor
      int    expPort;
      resp_t e;
      if (monitorOn) begin
         expPort = -1;
         if (rstSeen) begin
            expRd0 = '0;
            expRd1 = '0;
         end
         if (sb.size() > 0 && sb[0].due == cycleNo) begin
            e = sb.pop_front();
            if (!rstSeen) begin
               expPort = e.port;
               if (e.port == 0) expRd0 = e.rdata;
               else             expRd1 = e.rdata;
            end
         end
         checks++;
         if (m0_resp_valid !== (expPort == 0)) begin
            errors++;
            $display("[TB] FAIL m0_resp_valid cyc %0d got %b want %b", cycleNo, m0_resp_valid, expPort == 0);
         end
         checks++;
         if (m1_resp_valid !== (expPort == 1)) begin
            errors++;
            $display("[TB] FAIL m1_resp_valid cyc %0d got %b want %b", cycleNo, m1_resp_valid, expPort == 1);
         end
         checks++;
         if (m0_rdata !== expRd0) begin
            errors++;
            $display("[TB] FAIL m0_rdata cyc %0d got %h want %h", cycleNo, m0_rdata, expRd0);
         end
         checks++;
         if (m1_rdata !== expRd1) begin
            errors++;
            $display("[TB] FAIL m1_rdata cyc %0d got %h want %h", cycleNo, m1_rdata, expRd1);
         end
      end
   end

   task automatic applyStimulus(input logic r, input logic v0, input logic we0, input logic [31:0] a0,
                                input logic [31:0] wd0, input logic v1, input logic we1,
                                input logic [31:0] a1, input logic [31:0] wd1, input logic lock,
                                input logic [31:0] rd);
      rst = r;
      m0_valid = v0; m0_we = we0; m0_addr = a0; m0_wdata = wd0;
      m1_valid = v1; m1_we = we1; m1_addr = a1; m1_wdata = wd1;
      m1_lock = lock; mem_rd = rd;
      #2;
   endtask

   task automatic expectResp(input int port, input logic [31:0] rdata);
      resp_t e;
      e.port  = port;
      e.rdata = rdata;
      e.due   = cycleNo + 1;
      sb.push_back(e);
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
   endtask

   task automatic test_reset();
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h40, 32'h11, 1'b1, 1'b1, 32'h44, 32'h22, 1'b1, 32'hAAAA_5555);
      @(posedge clk);
      @(posedge clk);
      #1 monitorOn = 1'b1;
      @(negedge clk);
      #2;
      checks++;
      if ({m1_ready, m0_ready} !== 2'b00) begin
         errors++; $display("[TB] FAIL reset_ready got %b want 00", {m1_ready, m0_ready});
      end
      checks++;
      if ({mem_we, mem_addr, mem_wd} !== 65'd0) begin
         errors++; $display("[TB] FAIL reset_mem got we=%b addr=%h wd=%h want zeros", mem_we, mem_addr, mem_wd);
      end
      checks++;
      if (core_stall !== 1'b1) begin
         errors++; $display("[TB] FAIL reset_stall got %b want 1", core_stall);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      checks++;
      if (lock_active !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_lock got %b want 0", lock_active);
      end
      @(negedge clk);
   endtask

   task automatic test_core_load();
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEAD_BEEF);
      checks++;
      if ({m1_ready, m0_ready} !== 2'b01) begin
         errors++; $display("[TB] FAIL load_ready got %b want 01", {m1_ready, m0_ready});
      end
      checks++;
      if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin
         errors++; $display("[TB] FAIL load_mem got addr=%h we=%b want 10/0", mem_addr, mem_we);
      end
      checks++;
      if (core_stall !== 1'b0) begin
         errors++; $display("[TB] FAIL load_stall got %b want 0", core_stall);
      end
      expectResp(0, 32'hDEAD_BEEF);
      @(negedge clk);
   endtask

   task automatic test_store();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 32'h5555_AAAA);
      checks++;
      if ({m1_ready, m0_ready} !== 2'b10) begin
         errors++; $display("[TB] FAIL store_ready got %b want 10", {m1_ready, m0_ready});
      end
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wd !== 32'h1234_5678) begin
         errors++; $display("[TB] FAIL store_mem got we=%b addr=%h wd=%h want 1/20/12345678", mem_we, mem_addr, mem_wd);
      end
      expectResp(1, 32'h0);
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [31:0] addr [3];
      logic [31:0] rd   [3];
      logic        we   [3];
      addr = '{32'h30, 32'h34, 32'h38};
      rd   = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
      we   = '{1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, we[i], addr[i], 32'h99 + i, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, rd[i]);
         checks++;
         if (m0_ready !== 1'b1 || mem_addr !== addr[i] || mem_we !== we[i]) begin
            errors++; $display("[TB] FAIL b2b_grant[%0d] got rdy=%b addr=%h we=%b want 1/%h/%b",
                               i, m0_ready, mem_addr, mem_we, addr[i], we[i]);
         end
         expectResp(0, we[i] ? 32'h0 : rd[i]);
         @(negedge clk);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h7777_7777);
      checks++;
      if ({m1_ready, m0_ready, mem_we, mem_addr, mem_wd} !== 67'd0) begin
         errors++; $display("[TB] FAIL idle_mem got rdy=%b we=%b addr=%h wd=%h want zeros",
                            {m1_ready, m0_ready}, mem_we, mem_addr, mem_wd);
      end
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      bit [1:0] gnt [4];
      gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 32'hA000_0000 + i);
         checks++;
         if ({m1_ready, m0_ready} !== gnt[i]) begin
            errors++; $display("[TB] FAIL rr_grant[%0d] got %b want %b", i, {m1_ready, m0_ready}, gnt[i]);
         end
         checks++;
         if (core_stall !== gnt[i][1]) begin
            errors++; $display("[TB] FAIL rr_stall[%0d] got %b want %b", i, core_stall, gnt[i][1]);
         end
         checks++;
         if (mem_addr !== (gnt[i][0] ? 32'h100 : 32'h200)) begin
            errors++; $display("[TB] FAIL rr_addr[%0d] got %h", i, mem_addr);
         end
         expectResp(gnt[i][0] ? 0 : 1, 32'hA000_0000 + i);
         @(negedge clk);
      end
   endtask

   task automatic test_lock_bound();
      bit [1:0] gnt  [8];
      bit       lact [8];
      gnt  = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10};
      lact = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      doReset();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 1'b1, 32'h400, 32'hCAFE_0000, 1'b1,
                       32'hB000_0000 + i);
         checks++;
         if ({m1_ready, m0_ready} !== gnt[i]) begin
            errors++; $display("[TB] FAIL lock_grant[%0d] got %b want %b", i, {m1_ready, m0_ready}, gnt[i]);
         end
         checks++;
         if (lock_active !== lact[i]) begin
            errors++; $display("[TB] FAIL lock_active[%0d] got %b want %b", i, lock_active, lact[i]);
         end
         checks++;
         if (mem_we !== gnt[i][1] || (gnt[i][1] && mem_wd !== 32'hCAFE_0000)) begin
            errors++; $display("[TB] FAIL lock_write[%0d] got we=%b wd=%h", i, mem_we, mem_wd);
         end
         expectResp(gnt[i][0] ? 0 : 1, gnt[i][0] ? 32'hB000_0000 + i : 32'h0);
         @(negedge clk);
      end
   endtask

   task automatic test_early_release();
      bit [1:0] gnt  [5];
      bit       lact [5];
      bit       lock [5];
      gnt  = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b10};
      lact = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      lock = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      doReset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 1'b1, 1'b0, 32'h600, 32'h0, lock[i],
                       32'hC000_0000 + i);
         checks++;
         if ({m1_ready, m0_ready} !== gnt[i]) begin
            errors++; $display("[TB] FAIL rel_grant[%0d] got %b want %b", i, {m1_ready, m0_ready}, gnt[i]);
         end
         checks++;
         if (lock_active !== lact[i]) begin
            errors++; $display("[TB] FAIL rel_lock[%0d] got %b want %b", i, lock_active, lact[i]);
         end
         expectResp(gnt[i][0] ? 0 : 1, 32'hC000_0000 + i);
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_lock();
      bit [1:0] gnt  [6];
      bit       lact [6];
      bit       rsts [6];
      gnt  = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10};
      lact = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      rsts = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      doReset();
      for (int i = 0; i < 6; i++) begin
         applyStimulus(rsts[i], 1'b1, 1'b0, 32'h700, 32'h0, 1'b1, 1'b0, 32'h800, 32'h0, 1'b1,
                       32'hD000_0000 + i);
         checks++;
         if ({m1_ready, m0_ready} !== gnt[i]) begin
            errors++; $display("[TB] FAIL mid_grant[%0d] got %b want %b", i, {m1_ready, m0_ready}, gnt[i]);
         end
         checks++;
         if (lock_active !== lact[i]) begin
            errors++; $display("[TB] FAIL mid_lock[%0d] got %b want %b", i, lock_active, lact[i]);
         end
         checks++;
         if (mem_addr !== (gnt[i][0] ? 32'h700 : (gnt[i][1] ? 32'h800 : 32'h0)) || mem_we !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_mem[%0d] got addr=%h we=%b", i, mem_addr, mem_we);
         end
         checks++;
         if (core_stall !== ~gnt[i][0]) begin
            errors++; $display("[TB] FAIL mid_stall[%0d] got %b want %b", i, core_stall, ~gnt[i][0]);
         end
         if (gnt[i] != 2'b00) expectResp(gnt[i][0] ? 0 : 1, 32'hD000_0000 + i);
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cycleNo);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_core_load();
      test_store();
      test_back_to_back();
      test_round_robin();
      test_lock_bound();
      test_early_release();
      test_reset_mid_lock();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("[TB] FAIL scoreboard_drain got %0d pending want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
